// File: rtl/stopwatch_time_counter_pkg.sv
// Shared stopwatch types and limits, also used by the display and BCD path.
package stopwatch_time_counter_pkg;

  localparam int unsigned TIME_W = 6;

  typedef logic [TIME_W-1:0] time_field_t;

  localparam time_field_t SEC_MAX = 6'd59;
  localparam time_field_t MIN_MAX = 6'd59;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  function automatic time_field_t field_next(input time_field_t value, input time_field_t last);
    return (value == last) ? '0 : value + 1'b1;
  endfunction

endpackage

// File: rtl/stopwatch_time_counter_tick_prescaler.sv
// Divides clk down to one tick per counted second; the fraction survives a pause.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic advance,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // A tick fires only from a cycle spent in RUN, so a pause edge can still
  // complete the current second. advance covers edges that leave the block in
  // RUN, including the one that enters it; cnt never sits at LAST outside RUN.
  always_comb begin
    tick = enable && !clear && (cnt == LAST);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else if (advance) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_time_counter.sv
// Stopwatch timekeeping core: start/stop/clear FSM, prescaler, cascaded h:m:s.
// Optional lap hold display is built when STOPWATCH_LAP_EN is defined.
module stopwatch_time_counter
  import stopwatch_time_counter_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned HOUR_MAX = 23
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_stop,
  input  logic              clear,
  input  logic              lap,
  output logic [TIME_W-1:0] sec,
  output logic [TIME_W-1:0] min,
  output logic [TIME_W-1:0] hour,
  output logic              running,
  output logic              sec_tick,
  output logic              wrap
);

  localparam time_field_t HOUR_LAST = time_field_t'(HOUR_MAX);

  state_t      state;
  state_t      state_nxt;
  logic        in_run;
  logic        advance;
  logic        tick;
  time_field_t live_sec;
  time_field_t live_min;
  time_field_t live_hour;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else if (start_stop) begin
      case (state)
        IDLE:    state_nxt = RUN;
        RUN:     state_nxt = PAUSE;
        PAUSE:   state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    in_run  = (state == RUN);
    advance = (state_nxt == RUN);
    running = in_run;
  end

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .enable (in_run),
    .advance(advance),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      live_sec  <= '0;
      live_min  <= '0;
      live_hour <= '0;
      sec_tick  <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      sec_tick <= tick;
      wrap     <= 1'b0;
      if (tick) begin
        live_sec <= field_next(live_sec, SEC_MAX);
        if (live_sec == SEC_MAX) begin
          live_min <= field_next(live_min, MIN_MAX);
          if (live_min == MIN_MAX) begin
            live_hour <= field_next(live_hour, HOUR_LAST);
            wrap      <= (live_hour == HOUR_LAST);
          end
        end
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic        hold;
  time_field_t snap_sec;
  time_field_t snap_min;
  time_field_t snap_hour;

  // A lap pulse releases an existing hold in any state; it only captures in RUN.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hold      <= 1'b0;
      snap_sec  <= '0;
      snap_min  <= '0;
      snap_hour <= '0;
    end else if (lap) begin
      if (hold) begin
        hold <= 1'b0;
      end else if (in_run) begin
        hold      <= 1'b1;
        snap_sec  <= live_sec;
        snap_min  <= live_min;
        snap_hour <= live_hour;
      end
    end
  end

  always_comb begin
    sec  = hold ? snap_sec  : live_sec;
    min  = hold ? snap_min  : live_min;
    hour = hold ? snap_hour : live_hour;
  end
`else
  logic unused_lap;

  always_comb begin
    unused_lap = lap;
    sec        = live_sec;
    min        = live_min;
    hour       = live_hour;
  end
`endif

endmodule
